// File: rtl/prbs_pkg.sv
// Shared definitions for the parallel PRBS generator.
// Holds the mode encoding, the ITU-T O.150 tap table (N, M per mode) and the
// active-length mask helper. Modes 5..7 fall through to PRBS31 everywhere.
package prbs_pkg;

  localparam logic [2:0] MODE_PRBS7  = 3'd0;
  localparam logic [2:0] MODE_PRBS9  = 3'd1;
  localparam logic [2:0] MODE_PRBS15 = 3'd2;
  localparam logic [2:0] MODE_PRBS23 = 3'd3;
  localparam logic [2:0] MODE_PRBS31 = 3'd4;

  localparam int unsigned StateW = 31;

  // Bit index of the length tap, N-1.
  function automatic logic [4:0] tap_hi(logic [2:0] mode);
    case (mode)
      MODE_PRBS7:  return 5'd6;
      MODE_PRBS9:  return 5'd8;
      MODE_PRBS15: return 5'd14;
      MODE_PRBS23: return 5'd22;
      default:     return 5'd30;
    endcase
  endfunction

  // Bit index of the feedback tap, M-1.
  function automatic logic [4:0] tap_lo(logic [2:0] mode);
    case (mode)
      MODE_PRBS7:  return 5'd5;
      MODE_PRBS9:  return 5'd4;
      MODE_PRBS15: return 5'd13;
      MODE_PRBS23: return 5'd17;
      default:     return 5'd27;
    endcase
  endfunction

  // Ones in the low N bits; also serves as the all-ones restart state.
  function automatic logic [30:0] len_mask(logic [2:0] mode);
    case (mode)
      MODE_PRBS7:  return 31'h0000_007F;
      MODE_PRBS9:  return 31'h0000_01FF;
      MODE_PRBS15: return 31'h0000_7FFF;
      MODE_PRBS23: return 31'h007F_FFFF;
      default:     return 31'h7FFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/prbs_advance.sv
// Combinational W-step Fibonacci LFSR advance.
// Ports:
//   s_i      current 31-bit state (bits above N are zero)
//   mode_i   latched polynomial mode
//   word_o   W output bits, earliest bit in word_o[W-1]
//   s_next_o state after W bit steps
module prbs_advance
  import prbs_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [30:0]  s_i,
  input  logic [2:0]   mode_i,
  output logic [W-1:0] word_o,
  output logic [30:0]  s_next_o
);

  logic [30:0] st;
  logic [30:0] mask;
  logic [4:0]  hi;
  logic [4:0]  lo;
  logic        b;

  always_comb begin
    hi     = tap_hi(mode_i);
    lo     = tap_lo(mode_i);
    mask   = len_mask(mode_i);
    st     = s_i;
    b      = 1'b0;
    word_o = '0;
    for (int i = 0; i < W; i++) begin
      b      = st[hi] ^ st[lo];
      st     = {st[29:0], b} & mask;
      // Shifting left each step leaves the first bit in the MSB.
      word_o = (word_o << 1) | W'(b);
    end
    s_next_o = st;
  end

endmodule

// File: rtl/prbs_gen_par.sv
// Parametrised parallel PRBS generator (PRBS7/9/15/23/31), W bits per clock.
// Ports:
//   clk, rst     single clock, synchronous active-high reset
//   en           advance W bits this cycle
//   mode         polynomial select, latched only on seed_load
//   seed_load    load seed (masked to N) and mode; start state = seed
//   seed         31-bit seed
//   invert       live output inversion
//   inj_err      flip dout[W-1] of the word produced this cycle
//   dout         PRBS word, MSB-first
//   dout_valid   dout updated this cycle
//   wrap         state after this word equals the start state
//   lockup       sticky all-zero-state detection, cleared by rst only
module prbs_gen_par
  import prbs_pkg::*;
#(
  parameter int unsigned W        = 8,
  parameter logic [2:0]  DEF_MODE = 3'd4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [2:0]   mode,
  input  logic         seed_load,
  input  logic [30:0]  seed,
  input  logic         invert,
  input  logic         inj_err,
  output logic [W-1:0] dout,
  output logic         dout_valid,
  output logic         wrap,
  output logic         lockup
);

  logic [2:0]   mode_q, mode_d;
  logic [30:0]  s_q, s_d;
  logic [30:0]  start_q, start_d;
  logic [W-1:0] dout_q, dout_d;
  logic         valid_q, valid_d;
  logic         wrap_q, wrap_d;
  logic         lock_q, lock_d;

  logic [W-1:0] adv_word;
  logic [30:0]  adv_s;
  logic [30:0]  seed_m;
  logic         cur_zero;

  prbs_advance #(
    .W (W)
  ) u_advance (
    .s_i      (s_q),
    .mode_i   (mode_q),
    .word_o   (adv_word),
    .s_next_o (adv_s)
  );

  always_comb begin
    mode_d   = mode_q;
    s_d      = s_q;
    start_d  = start_q;
    dout_d   = dout_q;
    valid_d  = 1'b0;
    wrap_d   = 1'b0;
    lock_d   = lock_q;
    seed_m   = seed & len_mask(mode);
    cur_zero = ((s_q & len_mask(mode_q)) == '0);

    if (seed_load) begin
      mode_d = mode;
      if (seed_m == '0) begin
        s_d    = len_mask(mode);
        lock_d = 1'b1;
      end else begin
        s_d = seed_m;
      end
      start_d = s_d;
    end else if (cur_zero) begin
      // All-zero state would never leave zero: restart from all ones.
      s_d    = len_mask(mode_q);
      lock_d = 1'b1;
    end else if (en) begin
      s_d     = adv_s;
      dout_d  = adv_word ^ {W{invert}} ^ (W'(inj_err) << (W - 1));
      valid_d = 1'b1;
      wrap_d  = (adv_s == start_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= DEF_MODE;
      s_q     <= len_mask(DEF_MODE);
      start_q <= len_mask(DEF_MODE);
      dout_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      s_q     <= s_d;
      start_q <= start_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      lock_q  <= lock_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign wrap       = wrap_q;
  assign lockup     = lock_q;

endmodule

// File: tb/tb_prbs_gen_par.sv
module tb_prbs_gen_par;

  logic        clk = 1'b0;
  logic        rst, en, seed_load, invert, inj_err;
  logic [2:0]  mode;
  logic [30:0] seed;
  logic [7:0]  dout;
  logic        dout_valid, wrap, lockup;
  logic [31:0] dout32;
  logic        valid32, wrap32, lock32;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  prbs_gen_par #(.W(8), .DEF_MODE(3'd4)) u_dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .seed_load(seed_load), .seed(seed),
    .invert(invert), .inj_err(inj_err), .dout(dout), .dout_valid(dout_valid),
    .wrap(wrap), .lockup(lockup)
  );

  prbs_gen_par #(.W(32), .DEF_MODE(3'd4)) u_dut32 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .seed_load(seed_load), .seed(seed),
    .invert(invert), .inj_err(inj_err), .dout(dout32), .dout_valid(valid32),
    .wrap(wrap32), .lockup(lock32)
  );

  // Reference model: the bit stream as the recurrence b[k] = b[k-N] ^ b[k-M],
  // with wrap derived from the bit position modulo 2^N-1.
  bit          hist[$];
  int          m_n, m_m;
  longint      m_pos, m_period;
  logic [7:0]  m_dout;
  logic        m_valid, m_wrap, m_lock;

  function automatic void m_taps(input logic [2:0] md);
    case (md)
      3'd0:    begin m_n = 7;  m_m = 6;  end
      3'd1:    begin m_n = 9;  m_m = 5;  end
      3'd2:    begin m_n = 15; m_m = 14; end
      3'd3:    begin m_n = 23; m_m = 18; end
      default: begin m_n = 31; m_m = 28; end
    endcase
  endfunction

  function automatic void m_load(input logic [2:0] md, input logic [30:0] sd);
    longint v;
    m_taps(md);
    m_period = (longint'(1) << m_n) - 1;
    v = longint'(sd) & m_period;
    if (v == 0) begin
      v = m_period;
      m_lock = 1'b1;
    end
    hist.delete();
    // Oldest history bit is the state's top active bit.
    for (int i = m_n - 1; i >= 0; i--) hist.push_back(bit'(v >> i));
    m_pos = 0;
  endfunction

  function automatic bit m_bit();
    bit b;
    b = hist[hist.size() - m_n] ^ hist[hist.size() - m_m];
    hist.push_back(b);
    if (hist.size() > 64) void'(hist.pop_front());
    return b;
  endfunction

  function automatic void m_clock();
    logic [7:0] w;
    if (rst) begin
      m_lock = 1'b0;
      m_load(3'd4, 31'h7FFF_FFFF);
      m_dout = '0; m_valid = 1'b0; m_wrap = 1'b0;
    end else if (seed_load) begin
      m_load(mode, seed);
      m_valid = 1'b0; m_wrap = 1'b0;
    end else if (en) begin
      w = '0;
      for (int i = 0; i < 8; i++) w = {w[6:0], m_bit()};
      m_dout  = w ^ {8{invert}} ^ {inj_err, 7'b0};
      m_valid = 1'b1;
      m_pos   = (m_pos + 8) % m_period;
      m_wrap  = (m_pos == 0);
    end else begin
      m_valid = 1'b0; m_wrap = 1'b0;
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".dout"}, 64'(dout), 64'(m_dout));
    chk({tag, ".valid"}, 64'(dout_valid), 64'(m_valid));
    chk({tag, ".wrap"}, 64'(wrap), 64'(m_wrap));
    chk({tag, ".lockup"}, 64'(lockup), 64'(m_lock));
  endtask

  // Model follows the inputs sampled at this edge; DUT sampled 1 ns later.
  task automatic cyc();
    m_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic r, input logic e, input logic sl, input logic [2:0] md,
                        input logic [30:0] sd, input logic inv, input logic inj);
    rst = r; en = e; seed_load = sl; mode = md; seed = sd; invert = inv; inj_err = inj;
  endtask

  typedef struct {
    logic       en;
    logic       inv;
    logic       inj;
    logic [7:0] exp_dout;
    logic       exp_valid;
  } vec_t;

  vec_t vecs[5];
  int   wrap_cnt;

  initial begin
    // PRBS7 from all ones: 0000001 0 | 0000 1100 | 0010 1000 | 1111 0010
    vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h02, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 8'h0C, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 8'h0C, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 8'hD7, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 8'h72, 1'b1};

    // Reset state and first DEF_MODE (PRBS31) words.
    set_in(1, 0, 0, 3'd0, 31'd0, 0, 0);
    cyc(); cyc();
    chk_model("reset");
    set_in(0, 1, 0, 3'd0, 31'd0, 0, 0);
    cyc();
    chk_model("prbs31_w8_first");
    chk("prbs31_w32_first", 64'(dout32), 64'h0000_000E);
    chk("prbs31_w32_valid", 64'(valid32), 64'd1);

    // Table: PRBS7 from all ones.
    set_in(0, 1, 1, 3'd0, 31'h7F, 0, 0);
    cyc();
    chk_model("prbs7_load");
    for (int i = 0; i < 5; i++) begin
      set_in(0, vecs[i].en, 0, 3'd0, 31'd0, vecs[i].inv, vecs[i].inj);
      cyc();
      chk($sformatf("tbl%0d.dout", i), 64'(dout), 64'(vecs[i].exp_dout));
      chk($sformatf("tbl%0d.valid", i), 64'(dout_valid), 64'(vecs[i].exp_valid));
    end

    // Wrap: 254 PRBS7 words, second half inverted, mode input wiggling.
    set_in(0, 0, 1, 3'd0, 31'h7F, 0, 0);
    cyc();
    wrap_cnt = 0;
    for (int i = 1; i <= 254; i++) begin
      set_in(0, 1, 0, 3'(i), 31'd0, i > 127, 0);
      cyc();
      chk_model("wrap_run");
      if (wrap) wrap_cnt++;
      if (i == 127 || i == 254) chk($sformatf("wrap_at_%0d", i), 64'(wrap), 64'd1);
    end
    chk("wrap_count", 64'(wrap_cnt), 64'd2);

    // Zero seed on PRBS15: lock-up recovery, sticky until rst.
    set_in(0, 1, 1, 3'd2, 31'h7FFF_8000, 0, 0);
    cyc();
    chk("lock_set", 64'(lockup), 64'd1);
    for (int i = 0; i < 20; i++) begin
      set_in(0, 1, 0, 3'd2, 31'd0, 0, 0);
      cyc();
      chk_model("prbs15_ones");
    end
    set_in(0, 0, 1, 3'd1, 31'h1A5, 0, 0);
    cyc();
    chk("lock_sticky", 64'(lockup), 64'd1);

    // Error injection on one word, then en 1-on/2-off.
    for (int i = 0; i < 12; i++) begin
      set_in(0, 1, 0, 3'd1, 31'd0, 0, i == 4);
      cyc();
      chk_model("inj_run");
    end
    for (int i = 0; i < 18; i++) begin
      set_in(0, (i % 3) == 0, 0, 3'd1, 31'd0, 0, 0);
      cyc();
      chk_model("en_toggle");
    end

    // rst together with seed_load and en mid-stream.
    set_in(1, 1, 1, 3'd0, 31'h55, 1, 1);
    cyc();
    chk_model("rst_mid");
    set_in(0, 1, 0, 3'd0, 31'd0, 0, 0);
    cyc();
    chk_model("rst_mid_first");
    chk("rst_mid_w32", 64'(dout32), 64'h0000_000E);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      logic        sl;
      logic [30:0] sd;
      sl = ($urandom_range(0, 19) == 0);
      sd = 31'($urandom);
      if ($urandom_range(0, 3) == 0) sd = sd & 31'h7FFF_FF80;
      if ($urandom_range(0, 7) == 0) sd = 31'd0;
      set_in($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, sl,
             3'($urandom_range(0, 7)), sd, 1'($urandom), $urandom_range(0, 7) == 0);
      cyc();
      chk_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
